// File: rtl/fifo_bank_np_if.sv
// fifo_bank_np_if: bundle of the per-port write/read handshake and the status
// outputs of the fifo_bank_np router input-buffer bank.
//   master modport : the link receivers / arbiter side (drives writes, pops, clear_err)
//   slave  modport : the FIFO bank itself
// Signals (port i occupies slice i of each vector):
//   data_in/valid_in    write flits and write requests
//   ready_in            pop requests from the arbiter
//   data_out/valid_out  head flit (first-word fall-through) and non-empty
//   full_out/afull_out  count == DEPTH / count >= AFULL_THRESH
//   pressure_out        per-port occupancy, CW bits per port
//   overflow_out        sticky "write dropped while full"
//   clear_err           clears every overflow_out bit
//   peak_out            only when FIFO_BANK_PEAK_EN is defined
interface fifo_bank_np_if #(
  parameter int NUM_PORTS = 5,
  parameter int DEPTH     = 8,
  parameter int DATASIZE  = 40
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [NUM_PORTS*DATASIZE-1:0] data_in;
  logic [NUM_PORTS-1:0]          valid_in;
  logic [NUM_PORTS-1:0]          ready_in;
  logic [NUM_PORTS*DATASIZE-1:0] data_out;
  logic [NUM_PORTS-1:0]          valid_out;
  logic [NUM_PORTS-1:0]          full_out;
  logic [NUM_PORTS-1:0]          afull_out;
  logic [NUM_PORTS*CW-1:0]       pressure_out;
  logic [NUM_PORTS-1:0]          overflow_out;
  logic                          clear_err;
`ifdef FIFO_BANK_PEAK_EN
  logic [NUM_PORTS*CW-1:0]       peak_out;

  modport master (
    output data_in, valid_in, ready_in, clear_err,
    input  data_out, valid_out, full_out, afull_out, pressure_out, overflow_out, peak_out
  );
  modport slave (
    input  data_in, valid_in, ready_in, clear_err,
    output data_out, valid_out, full_out, afull_out, pressure_out, overflow_out, peak_out
  );
`else
  modport master (
    output data_in, valid_in, ready_in, clear_err,
    input  data_out, valid_out, full_out, afull_out, pressure_out, overflow_out
  );
  modport slave (
    input  data_in, valid_in, ready_in, clear_err,
    output data_out, valid_out, full_out, afull_out, pressure_out, overflow_out
  );
`endif
endinterface

// File: rtl/fifo_bank_np.sv
// fifo_bank_np: NUM_PORTS independent first-word-fall-through FIFOs used as the
// input buffers of a router. Each FIFO reports its occupancy (pressure), full,
// almost-full and a sticky overflow flag.
// Ports:
//   fifo_clk : clock, all state updates on the rising edge
//   rst_n    : asynchronous active-low reset (storage array is not reset)
//   bus      : fifo_bank_np_if.slave -- data/valid/ready per port, status outputs,
//              shared clear_err
// Optional feature: define FIFO_BANK_PEAK_EN to add bus.peak_out, the per-port
// maximum count seen since reset or the last clear_err.
// The interface instance must be built with the same NUM_PORTS/DEPTH/DATASIZE.
module fifo_bank_np #(
  parameter int NUM_PORTS    = 5,
  parameter int DEPTH        = 8,
  parameter int DATASIZE     = 40,
  parameter int AFULL_THRESH = 6
) (
  input logic           fifo_clk,
  input logic           rst_n,
  fifo_bank_np_if.slave bus
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int AW = $clog2(DEPTH);

  generate
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
      logic [DATASIZE-1:0] mem [DEPTH];
      logic [AW-1:0]       wptr_reg;
      logic [AW-1:0]       rptr_reg;
      logic [CW-1:0]       count_reg;
      logic                ovf_reg;
      logic                full;
      logic                not_empty;
      logic                rd;
      logic                wr;
      logic                drop;

      assign full      = (count_reg == CW'(DEPTH));
      assign not_empty = (count_reg != '0);
      assign rd        = bus.ready_in[gi] && not_empty;
      // A same-cycle pop frees a slot, so a full FIFO still accepts a write.
      assign wr        = bus.valid_in[gi] && (!full || rd);
      assign drop      = bus.valid_in[gi] && !wr;

      // Storage carries no reset so it can map onto plain RAM.
      always_ff @(posedge fifo_clk) begin
        if (wr) begin
          mem[wptr_reg] <= bus.data_in[gi*DATASIZE +: DATASIZE];
        end
      end

      always_ff @(posedge fifo_clk or negedge rst_n) begin
        if (!rst_n) begin
          wptr_reg  <= '0;
          rptr_reg  <= '0;
          count_reg <= '0;
          ovf_reg   <= 1'b0;
        end else begin
          if (wr) wptr_reg <= wptr_reg + AW'(1);
          if (rd) rptr_reg <= rptr_reg + AW'(1);
          case ({wr, rd})
            2'b10:   count_reg <= count_reg + CW'(1);
            2'b01:   count_reg <= count_reg - CW'(1);
            default: count_reg <= count_reg;
          endcase
          // A new drop wins over a simultaneous clear.
          if (drop)               ovf_reg <= 1'b1;
          else if (bus.clear_err) ovf_reg <= 1'b0;
        end
      end

      // All status outputs decode the same registered count, so they agree.
      assign bus.valid_out[gi]                     = not_empty;
      assign bus.full_out[gi]                      = full;
      assign bus.afull_out[gi]                     = (count_reg >= CW'(AFULL_THRESH));
      assign bus.pressure_out[gi*CW +: CW]         = count_reg;
      assign bus.overflow_out[gi]                  = ovf_reg;
      assign bus.data_out[gi*DATASIZE +: DATASIZE] = not_empty ? mem[rptr_reg] : '0;

`ifdef FIFO_BANK_PEAK_EN
      logic [CW-1:0] peak_reg;

      // Tracks the registered count, so a new maximum shows one cycle after
      // the count reaches it. clear_err restarts tracking from the live count.
      always_ff @(posedge fifo_clk or negedge rst_n) begin
        if (!rst_n) begin
          peak_reg <= '0;
        end else if (bus.clear_err) begin
          peak_reg <= count_reg;
        end else if (count_reg > peak_reg) begin
          peak_reg <= count_reg;
        end
      end

      assign bus.peak_out[gi*CW +: CW] = peak_reg;
`endif
    end
  endgenerate
endmodule

// File: tb/tb_fifo_bank_np.sv
module tb_fifo_bank_np;
  localparam int NP    = 5;
  localparam int DEPTH = 8;
  localparam int DW    = 40;
  localparam int AF    = 6;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic fifo_clk = 1'b0;
  logic rst_n    = 1'b0;
  always #5 fifo_clk = ~fifo_clk;

  fifo_bank_np_if #(.NUM_PORTS(NP), .DEPTH(DEPTH), .DATASIZE(DW)) bus ();

  fifo_bank_np #(
    .NUM_PORTS(NP), .DEPTH(DEPTH), .DATASIZE(DW), .AFULL_THRESH(AF)
  ) dut (
    .fifo_clk(fifo_clk),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  // Reference model: each port is a queue of flits plus an occupancy number,
  // an overflow flag and a running maximum.
  logic [DW-1:0] exp_q [NP][$];
  int            cnt   [NP];
  bit            ovf   [NP];
  int            peak  [NP];

  // Snapshot of what the DUT must show during the cycle a step is driven.
  typedef struct packed {
    logic [NP-1:0][CW-1:0] cnt;
    logic [NP-1:0]         ovf;
    logic [NP-1:0][CW-1:0] peak;
  } status_t;
  status_t st_q[$];
  status_t mon_s;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int port, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s port %0d: got %h, expected %h at %0t", name, port, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NP; i++) begin
      exp_q[i].delete();
      cnt[i]  = 0;
      ovf[i]  = 1'b0;
      peak[i] = 0;
    end
  endtask

  // Drive one cycle of inputs (applied at the following rising edge) and
  // record expectations: the visible status now, and accepted flits queued.
  task automatic step(input logic [NP-1:0] v, input logic [NP*DW-1:0] d,
                      input logic [NP-1:0] r, input bit clr);
    status_t s;
    bit rd, wr;
    @(posedge fifo_clk);
    #1;
    for (int i = 0; i < NP; i++) begin
      s.cnt[i]  = CW'(cnt[i]);
      s.ovf[i]  = ovf[i];
      s.peak[i] = CW'(peak[i]);
    end
    st_q.push_back(s);
    for (int i = 0; i < NP; i++) begin
      rd = r[i] && (cnt[i] > 0);
      wr = v[i] && ((cnt[i] < DEPTH) || rd);
      if (wr) exp_q[i].push_back(d[i*DW +: DW]);
      if (clr) peak[i] = cnt[i];
      else if (cnt[i] > peak[i]) peak[i] = cnt[i];
      if (v[i] && !wr) ovf[i] = 1'b1;
      else if (clr) ovf[i] = 1'b0;
      cnt[i] = cnt[i] + int'(wr) - int'(rd);
    end
    bus.valid_in  = v;
    bus.data_in   = d;
    bus.ready_in  = r;
    bus.clear_err = clr;
  endtask

  function automatic logic [NP*DW-1:0] one_flit(input int port, input logic [DW-1:0] val);
    logic [NP*DW-1:0] d;
    d = '0;
    d[port*DW +: DW] = val;
    return d;
  endfunction

  // Monitor: compares the DUT against each recorded snapshot; pops the model
  // queue whenever the DUT presents a head flit that is being consumed.
  always @(negedge fifo_clk) begin
    if (st_q.size() > 0) begin
      mon_s = st_q.pop_front();
      for (int i = 0; i < NP; i++) begin
        int c;
        c = int'(mon_s.cnt[i]);
        check("valid_out",    i, 64'(bus.valid_out[i]),    64'(c > 0));
        check("full_out",     i, 64'(bus.full_out[i]),     64'(c == DEPTH));
        check("afull_out",    i, 64'(bus.afull_out[i]),    64'(c >= AF));
        check("pressure_out", i, 64'(bus.pressure_out[i*CW +: CW]), 64'(c));
        check("overflow_out", i, 64'(bus.overflow_out[i]), 64'(mon_s.ovf[i]));
`ifdef FIFO_BANK_PEAK_EN
        check("peak_out",     i, 64'(bus.peak_out[i*CW +: CW]), 64'(mon_s.peak[i]));
`endif
        if (c > 0) begin
          if (exp_q[i].size() > 0) begin
            check("data_out", i, 64'(bus.data_out[i*DW +: DW]), 64'(exp_q[i][0]));
            if (bus.ready_in[i]) void'(exp_q[i].pop_front());
          end else begin
            check("model_queue", i, 64'(0), 64'(1));
          end
        end else begin
          check("data_out_idle", i, 64'(bus.data_out[i*DW +: DW]), 64'(0));
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int rate [NP];
    int seq  [NP];
    logic [NP-1:0]    v, r;
    logic [NP*DW-1:0] d;

    bus.valid_in  = '0;
    bus.ready_in  = '0;
    bus.data_in   = '0;
    bus.clear_err = 1'b0;
    model_clear();

    // Reset state.
    #2;
    check("rst_valid",    0, 64'(bus.valid_out),    64'(0));
    check("rst_full",     0, 64'(bus.full_out),     64'(0));
    check("rst_afull",    0, 64'(bus.afull_out),    64'(0));
    check("rst_overflow", 0, 64'(bus.overflow_out), 64'(0));
    check("rst_pressure", 0, 64'(bus.pressure_out), 64'(0));
    check("rst_data",     0, 64'(bus.data_out[DW-1:0]), 64'(0));
    #10 rst_n = 1'b1;

    // Reset mid-traffic: three flits into port 0 plus an overflow on port 1,
    // then an asynchronous reset between clock edges.
    for (int k = 0; k < 3; k++) step(5'b00001, one_flit(0, DW'(40'h50 + k)), '0, 1'b0);
    for (int k = 0; k < 9; k++) step(5'b00010, one_flit(1, DW'(40'h60 + k)), '0, 1'b0);
    step('0, '0, '0, 1'b0);
    @(posedge fifo_clk);
    #1 bus.valid_in = '0;
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid",    0, 64'(bus.valid_out),    64'(0));
    check("arst_pressure", 0, 64'(bus.pressure_out[CW-1:0]), 64'(0));
    check("arst_overflow", 0, 64'(bus.overflow_out), 64'(0));
    model_clear();
    @(negedge fifo_clk);
    #2 rst_n = 1'b1;
    for (int k = 0; k < 4; k++) step('0, '0, '1, 1'b0);

    // Fill port 2 to full, then drain in order.
    for (int k = 1; k <= 8; k++) step(5'b00100, one_flit(2, DW'(k)), '0, 1'b0);
    step('0, '0, '0, 1'b0);
    for (int k = 0; k < 8; k++) step('0, '0, 5'b00100, 1'b0);
    step('0, '0, '0, 1'b0);

    // Overflow on port 1: 0xAA dropped, flag sticky until clear_err.
    for (int k = 1; k <= 8; k++) step(5'b00010, one_flit(1, DW'(40'h10 + k)), '0, 1'b0);
    step(5'b00010, one_flit(1, DW'(40'hAA)), '0, 1'b0);
    step('0, '0, '0, 1'b0);
    for (int k = 0; k < 8; k++) step('0, '0, 5'b00010, 1'b0);
    step('0, '0, '0, 1'b1);
    step('0, '0, '0, 1'b0);
    step('0, '0, '0, 1'b0);

    // Push and pop together while port 3 is full, across pointer wrap.
    for (int k = 1; k <= 8; k++) step(5'b01000, one_flit(3, DW'(40'h30 + k)), '0, 1'b0);
    for (int k = 0; k < 10; k++) step(5'b01000, one_flit(3, DW'(40'h40 + k)), 5'b01000, 1'b0);
    for (int k = 0; k < 9; k++) step('0, '0, 5'b01000, 1'b0);

    // Random traffic: each port at its own write rate, random pops.
    rate = '{20, 40, 60, 80, 95};
    seq  = '{0, 0, 0, 0, 0};
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < NP; i++) begin
        v[i] = ($urandom_range(0, 99) < rate[i]);
        r[i] = ($urandom_range(0, 1) == 1);
        d[i*DW +: DW] = {8'(i + 1), 32'(seq[i])};
        if (v[i]) seq[i]++;
      end
      step(v, d, r, ($urandom_range(0, 99) == 0));
    end
    for (int k = 0; k < 12; k++) step('0, '0, '1, 1'b0);

    // Peak tracking on port 4: fill to 5, drain to 1, then clear.
    step('0, '0, '0, 1'b1);
    for (int k = 0; k < 5; k++) step(5'b10000, one_flit(4, DW'(40'h70 + k)), '0, 1'b0);
    for (int k = 0; k < 4; k++) step('0, '0, 5'b10000, 1'b0);
    step('0, '0, '0, 1'b0);
    step('0, '0, '0, 1'b1);
    step('0, '0, '0, 1'b0);
    for (int k = 0; k < 3; k++) step('0, '0, '1, 1'b0);
    step('0, '0, '0, 1'b0);

    @(posedge fifo_clk);
    @(negedge fifo_clk);
    @(negedge fifo_clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
